fetch_pc_unit: RTL and testbench

//  Instruction-fetch / PC-sequencing stage that consumes the branch/jump control word produced by the control decoder.
//  It holds the PC, runs a req/ack fetch handshake to instruction memory, presents fetched words to decode, and

---
 rtl/pinca_ctrl_pkg.sv | 13 +
 rtl/branch_cmp.sv | 21 ++
 rtl/fetch_pc_unit.sv | 108 ++++++++++
 tb/tb_fetch_pc_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pinca_ctrl_pkg.sv
// pinca_ctrl_pkg: branch/jump control-word encodings and fetch FSM states
package pinca_ctrl_pkg;
  localparam logic [1:0] SEL_JMP = 2'b01;
  localparam logic [1:0] SEL_BR = 2'b10;
  localparam logic [1:0] PCT_REG = 2'b01;
  localparam logic [1:0] PCT_IDX = 2'b10;
  localparam logic [1:0] PCT_RSV = 2'b11;
  localparam logic [2:0] CMP_EQ = 3'b000;
  localparam logic [2:0] CMP_NE = 3'b101;
  localparam logic [2:0] CMP_LEZ = 3'b010;
  localparam logic [2:0] CMP_GTZ = 3'b011;
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;
endpackage

// File: rtl/branch_cmp.sv
// branch_cmp: evaluates the branch condition and flags unsupported compare codes
module branch_cmp
  import pinca_ctrl_pkg::*;
(
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [2:0]  compop,
  input  logic        unsig,
  output logic        cmp_true,
  output logic        cmp_err
);
  logic lez;
  always_comb begin
    lez = unsig ? rs_val == '0 : rs_val[31] | rs_val == '0;
    cmp_true = compop == CMP_EQ  ? rs_val == rt_val :
               compop == CMP_NE  ? rs_val != rt_val :
               compop == CMP_LEZ ? lez :
               compop == CMP_GTZ ? !lez : 1'b0;
    cmp_err = !(compop inside {CMP_EQ, CMP_NE, CMP_LEZ, CMP_GTZ});
  end
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC sequencing, imem req/ack fetch, decode hand-off and branch/jump redirect
module fetch_pc_unit
  import pinca_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [3:0]  MAX_WAIT = 4'd15
)(
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        id_ready,
  input  logic        br_valid,
  input  logic [1:0]  selbrjumpz,
  input  logic [1:0]  selpctype,
  input  logic [2:0]  compop,
  input  logic        unsig,
  input  logic [31:0] br_pc,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [15:0] imm16,
  input  logic [25:0] index26,
  output logic        br_taken,
  output logic        misalign,
  output logic        bus_err,
  output logic        cmp_err
);
  state_t state, nxt_state;
  logic [31:0] pc, nxt_pc, pend, nxt_pend, nxt_instr, nxt_instr_pc, target, br_pc4;
  logic [3:0] wait_cnt, nxt_wait;
  logic cmp_true, bad_cmp, err, take, misal, timeout;
  branch_cmp u_cmp (
    .rs_val(rs_val),
    .rt_val(rt_val),
    .compop(compop),
    .unsig(unsig),
    .cmp_true(cmp_true),
    .cmp_err(bad_cmp)
  );
  assign imem_req = state == REQ || state == DROP;
  assign imem_addr = pc;
  assign instr_valid = state == HOLD;
  always_comb begin
    br_pc4 = br_pc + 32'd4;
    target = selpctype == PCT_REG ? {rs_val[31:2], 2'b00} :
             selpctype == PCT_IDX ? {br_pc4[31:28], index26, 2'b00} :
             br_pc4 + {{14{imm16[15]}}, imm16, 2'b00};
    err = br_valid && (selbrjumpz == SEL_JMP || selbrjumpz == SEL_BR) &&
          (selpctype == PCT_RSV || (selbrjumpz == SEL_BR && bad_cmp));
    take = br_valid && !err && (selbrjumpz == SEL_JMP || (selbrjumpz == SEL_BR && cmp_true));
    misal = take && selpctype == PCT_REG && rs_val[1:0] != 2'b00;
    timeout = !imem_ack && wait_cnt == MAX_WAIT;
    nxt_state = state;
    nxt_pc = take ? target : pc;
    nxt_pend = pend;
    nxt_instr = instr;
    nxt_instr_pc = instr_pc;
    nxt_wait = 4'd0;
    case (state)
      IDLE: nxt_state = REQ;
      REQ: begin
        nxt_state = imem_ack ? (take ? REQ : HOLD) : (take ? DROP : REQ);
        nxt_pc = imem_ack && take ? target : imem_ack ? pc + 32'd4 : pc;
        nxt_pend = take ? target : pend;
        nxt_instr = imem_ack && !take ? imem_rdata : instr;
        nxt_instr_pc = imem_ack && !take ? pc : instr_pc;
        nxt_wait = imem_ack || timeout ? 4'd0 : wait_cnt + 4'd1;
      end
      HOLD: nxt_state = take || id_ready ? REQ : HOLD;
      DROP: begin
        // the abandoned fetch must still complete before the pending target is issued
        nxt_state = imem_ack ? REQ : DROP;
        nxt_pend = take ? target : pend;
        nxt_pc = imem_ack ? (take ? target : pend) : pc;
        nxt_wait = imem_ack || timeout ? 4'd0 : wait_cnt + 4'd1;
      end
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      pend <= RESET_PC;
      wait_cnt <= 4'd0;
      instr <= '0;
      instr_pc <= '0;
      br_taken <= 1'b0;
      misalign <= 1'b0;
      bus_err <= 1'b0;
      cmp_err <= 1'b0;
    end else begin
      state <= nxt_state;
      pc <= nxt_pc;
      pend <= nxt_pend;
      wait_cnt <= nxt_wait;
      instr <= nxt_instr;
      instr_pc <= nxt_instr_pc;
      br_taken <= take;
      misalign <= misal;
      bus_err <= imem_req && timeout;
      cmp_err <= err;
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: scoreboard bench; imem responder and decode monitor pop expected fetches
module tb_fetch_pc_unit;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic clock = 1'b0, reset = 1'b1;
  logic imem_req, imem_ack, instr_valid, id_ready, br_valid, unsig;
  logic br_taken, misalign, bus_err, cmp_err;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc, br_pc, rs_val, rt_val;
  logic [1:0] selbrjumpz, selpctype;
  logic [2:0] compop;
  logic [15:0] imm16;
  logic [25:0] index26;
  int checks = 0, failures = 0, granted = 0, used = 0, cyc = 0;
  int n_taken = 0, n_mis = 0, n_cmp = 0;
  int bus_cyc[$];
  logic [31:0] exp_addr[$], exp_ipc[$];
  logic [31:0] last, ea, ei;

  fetch_pc_unit dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .id_ready(id_ready),
    .br_valid(br_valid), .selbrjumpz(selbrjumpz), .selpctype(selpctype), .compop(compop),
    .unsig(unsig), .br_pc(br_pc), .rs_val(rs_val), .rt_val(rt_val), .imm16(imm16),
    .index26(index26), .br_taken(br_taken), .misalign(misalign), .bus_err(bus_err), .cmp_err(cmp_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // imem responder: acks only granted fetches and checks each acked address
  initial begin
    imem_ack = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clock);
      if (!reset || imem_ack) imem_ack = 1'b0;
      else if (imem_req && used < granted) begin
        used++;
        imem_ack = 1'b1;
        imem_rdata = imem_addr ^ K;
        ea = exp_addr.size() > 0 ? exp_addr.pop_front() : 'x;
        checks++;
        if (imem_addr !== ea) begin
          failures++;
          $display("FAIL fetch_addr got=%h want=%h", imem_addr, ea);
        end
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (instr_valid && id_ready) begin
      ei = exp_ipc.size() > 0 ? exp_ipc.pop_front() : 'x;
      checks++;
      if (instr_pc !== ei || instr !== (ei ^ K)) begin
        failures++;
        $display("FAIL decode_instr got pc=%h instr=%h want pc=%h instr=%h", instr_pc, instr, ei, ei ^ K);
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (br_taken) n_taken++;
    if (misalign) n_mis++;
    if (cmp_err) n_cmp++;
    if (bus_err) bus_cyc.push_back(cyc);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_acks();
    for (int i = 0; i < 100 && used < granted; i++) step(1);
    chk("ack_timeout", used, granted);
    granted = used;
  endtask

  task automatic fetch_one(input logic [31:0] a);
    exp_addr.push_back(a);
    granted++;
    last = a;
    wait_acks();
    step(2);
  endtask

  task automatic advance();
    logic [31:0] a;
    a = last;
    exp_ipc.push_back(a);
    id_ready = 1'b1;
    step(1);
    id_ready = 1'b0;
    fetch_one(a + 32'd4);
  endtask

  task automatic branch(input logic [1:0] s, input logic [1:0] p, input logic [2:0] c, input logic u,
                        input logic [31:0] b, input logic [31:0] r, input logic [31:0] t,
                        input logic [15:0] im, input logic [25:0] ix);
    {selbrjumpz, selpctype, compop, unsig, br_pc, rs_val, rt_val, imm16, index26} = {s, p, c, u, b, r, t, im, ix};
    br_valid = 1'b1;
    step(1);
    br_valid = 1'b0;
    step(2);
  endtask

  initial begin
    int t0, m0, c0;
    logic [31:0] a;
    {br_valid, selbrjumpz, selpctype, compop, unsig, br_pc, rs_val, rt_val, imm16, index26, id_ready} = '0;
    #2 reset = 1'b0;
    step(3);
    chk("reset_req", imem_req, 0);
    chk("reset_valid", instr_valid, 0);
    chk("reset_instr", instr, 0);
    chk("reset_ipc", instr_pc, 0);
    chk("reset_addr", imem_addr, 0);
    chk("reset_taken", br_taken, 0);
    reset = 1'b1;
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_addr.push_back(4 * i);
      exp_ipc.push_back(4 * i);
    end
    granted += 3;
    for (int i = 0; i < 200 && (used < granted || exp_ipc.size() > 0); i++) step(1);
    chk("seq_drain", exp_ipc.size(), 0);
    id_ready = 1'b0;
    fetch_one(32'h0C);
    chk("hold_ipc", instr_pc, 32'h0C);
    chk("hold_valid", instr_valid, 1);
    t0 = n_taken;
    branch(2'b10, 2'b00, 3'b000, 1'b0, 32'h100, 5, 5, 16'hFFFE, 0);
    chk("beq_taken", n_taken - t0, 1);
    chk("beq_flush", instr_valid, 0);
    fetch_one(32'h0FC);
    t0 = n_taken;
    branch(2'b10, 2'b00, 3'b000, 1'b0, 32'h100, 5, 6, 16'hFFFE, 0);
    chk("beq_ne_not_taken", n_taken - t0, 0);
    chk("beq_ne_hold", instr_valid, 1);
    advance();
    t0 = n_taken;
    branch(2'b10, 2'b00, 3'b010, 1'b0, 32'h200, 32'hFFFF_FFFF, 0, 16'h0004, 0);
    chk("blez_signed_taken", n_taken - t0, 1);
    fetch_one(32'h214);
    t0 = n_taken;
    branch(2'b10, 2'b00, 3'b010, 1'b1, 32'h200, 32'hFFFF_FFFF, 0, 16'h0004, 0);
    chk("blez_unsig_not_taken", n_taken - t0, 0);
    advance();
    t0 = n_taken;
    branch(2'b10, 2'b00, 3'b011, 1'b0, 32'h200, 0, 0, 16'h0004, 0);
    chk("bgtz_zero_not_taken", n_taken - t0, 0);
    advance();
    t0 = n_taken;
    branch(2'b01, 2'b10, 3'b000, 1'b0, 32'hF000_0010, 0, 0, 0, 26'h0000040);
    chk("j_taken", n_taken - t0, 1);
    fetch_one(32'hF000_0100);
    t0 = n_taken;
    m0 = n_mis;
    branch(2'b01, 2'b01, 3'b000, 1'b0, 0, 32'h203, 0, 0, 0);
    chk("jr_taken", n_taken - t0, 1);
    chk("jr_misalign", n_mis - m0, 1);
    fetch_one(32'h200);
    t0 = n_taken;
    c0 = n_cmp;
    branch(2'b10, 2'b00, 3'b111, 1'b0, 0, 0, 0, 16'h0010, 0);
    chk("bad_compop_err", n_cmp - c0, 1);
    chk("bad_compop_not_taken", n_taken - t0, 0);
    advance();
    c0 = n_cmp;
    branch(2'b01, 2'b11, 3'b000, 1'b0, 0, 0, 0, 0, 26'h100);
    chk("pctype_rsv_err", n_cmp - c0, 1);
    chk("pctype_rsv_not_taken", n_taken - t0, 0);
    advance();
    a = last + 32'd4;
    exp_ipc.push_back(last);
    id_ready = 1'b1;
    step(1);
    id_ready = 1'b0;
    step(1);
    chk("pending_req", imem_req, 1);
    chk("pending_addr", imem_addr, a);
    t0 = n_taken;
    branch(2'b01, 2'b10, 3'b000, 1'b0, 0, 0, 0, 0, 26'h100);
    chk("drop_taken", n_taken - t0, 1);
    chk("drop_addr_held", imem_addr, a);
    chk("drop_req_held", imem_req, 1);
    exp_addr.push_back(a);
    granted++;
    wait_acks();
    chk("redir_addr", imem_addr, 32'h400);
    chk("redir_req", imem_req, 1);
    chk("drop_no_valid", instr_valid, 0);
    fetch_one(32'h400);
    chk("redir_ipc", instr_pc, 32'h400);
    chk("redir_instr", instr, 32'h400 ^ K);
    exp_ipc.push_back(32'h400);
    bus_cyc.delete();
    id_ready = 1'b1;
    step(1);
    id_ready = 1'b0;
    step(40);
    chk("bus_err_seen", bus_cyc.size() >= 2, 1);
    if (bus_cyc.size() >= 2) chk("bus_err_period", bus_cyc[1] - bus_cyc[0], 16);
    chk("bus_err_addr", imem_addr, 32'h404);
    chk("bus_err_req", imem_req, 1);
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    chk("async_req", imem_req, 0);
    chk("async_addr", imem_addr, 0);
    chk("async_valid", instr_valid, 0);
    step(2);
    reset = 1'b1;
    fetch_one(32'h0);
    chk("addr_q_empty", exp_addr.size(), 0);
    chk("ipc_q_empty", exp_ipc.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end
endmodule
